// File: rtl/fa_cache_ctrl.sv
// fa_cache_ctrl: single-requester read/write sequencer in front of a
// fully associative cache, with write-through to backing memory.
//
// Reads look up the cache; a miss fetches from memory, fills the cache,
// then responds. Writes update the cache, then write memory.
// Only one transaction is in flight at a time.
//
// Optional feature macro: FA_CTRL_STATS_EN
//   Defined     -> hit_cnt_o / miss_cnt_o saturating read counters exist.
//   Not defined -> those ports and counters are absent.
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   req_valid_i/ready_o   request handshake (ready only in IDLE)
//   req_we_i/addr_i/wdata_i  request attributes
//   resp_valid_o          one-cycle completion pulse
//   resp_rdata_o/hit_o    read data (write echoes wdata) / read-hit flag
//   cache_addr_o/data_o   cache address / write data
//   cache_wen_o/ren_o     cache write / read enables
//   cache_hit_i/data_i    cache result, valid the cycle after ren
//   mem_req_o/we_o        memory request (held until ack) / write qualifier
//   mem_addr_o/wdata_o    memory address / write data
//   mem_ack_i/rdata_i     memory completion / read data (same cycle)
//   hit_cnt_o/miss_cnt_o  read hit / miss counters (stats build only)

module fa_cache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_hit_o,
    output logic [ADDR_W-1:0] cache_addr_o,
    output logic [DATA_W-1:0] cache_data_o,
    output logic              cache_wen_o,
    output logic              cache_ren_o,
    input  logic              cache_hit_i,
    input  logic [DATA_W-1:0] cache_data_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef FA_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_MEM_RD,
        S_FILL,
        S_WRITE,
        S_MEM_WR,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_next = req_we_i ? S_WRITE : S_LOOKUP;
                end
            end
            S_LOOKUP: w_next = S_CHECK;
            S_CHECK:  w_next = cache_hit_i ? S_RESP : S_MEM_RD;
            S_MEM_RD: w_next = mem_ack_i ? S_FILL : S_MEM_RD;
            S_FILL:   w_next = S_RESP;
            S_WRITE:  w_next = S_MEM_WR;
            S_MEM_WR: w_next = mem_ack_i ? S_RESP : S_MEM_WR;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // r_rdata starts as the write data so a write response echoes it;
    // read paths overwrite it with cache or memory data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_hit   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_addr  <= req_addr_i;
                        r_wdata <= req_wdata_i;
                        r_rdata <= req_wdata_i;
                        r_hit   <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (cache_hit_i) begin
                        r_rdata <= cache_data_i;
                        r_hit   <= 1'b1;
                    end
                end
                S_MEM_RD: begin
                    if (mem_ack_i) begin
                        r_rdata <= mem_rdata_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_rdata_o = '0;
        resp_hit_o   = 1'b0;
        cache_ren_o  = 1'b0;
        cache_wen_o  = 1'b0;
        cache_data_o = '0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        unique case (r_state)
            S_IDLE:   req_ready_o = 1'b1;
            S_LOOKUP: cache_ren_o = 1'b1;
            S_CHECK: begin
            end
            S_MEM_RD: mem_req_o = 1'b1;
            S_FILL: begin
                cache_wen_o  = 1'b1;
                cache_data_o = r_rdata;
            end
            S_WRITE: begin
                cache_wen_o  = 1'b1;
                cache_data_o = r_wdata;
            end
            S_MEM_WR: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                resp_rdata_o = r_rdata;
                resp_hit_o   = r_hit;
            end
            default: begin
            end
        endcase
    end

    assign cache_addr_o = r_addr;
    assign mem_addr_o   = r_addr;
    assign mem_wdata_o  = r_wdata;

`ifdef FA_CTRL_STATS_EN
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    // Only reads reach CHECK, so writes are never counted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_CHECK) begin
            if (cache_hit_i) begin
                if (r_hit_cnt != '1) begin
                    r_hit_cnt <= r_hit_cnt + 1'b1;
                end
            end else begin
                if (r_miss_cnt != '1) begin
                    r_miss_cnt <= r_miss_cnt + 1'b1;
                end
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_fa_cache_ctrl.sv
// tb_fa_cache_ctrl: randomized self-checking bench for fa_cache_ctrl.
// Cache and memory are behavioural responders; expectations come from a reference model.

module tb_fa_cache_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef FA_CTRL_STATS_EN
    localparam int CW = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic          resp_valid_o;
    logic [DW-1:0] resp_rdata_o;
    logic          resp_hit_o;
    logic [AW-1:0] cache_addr_o;
    logic [DW-1:0] cache_data_o;
    logic          cache_wen_o;
    logic          cache_ren_o;
    logic          cache_hit_i;
    logic [DW-1:0] cache_data_i;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_rdata_i;
`ifdef FA_CTRL_STATS_EN
    logic [CW-1:0] hit_cnt_o;
    logic [CW-1:0] miss_cnt_o;
`endif

    always #5 clk = ~clk;

    fa_cache_ctrl #(
        .ADDR_W(AW),
        .DATA_W(DW)
`ifdef FA_CTRL_STATS_EN
        ,
        .CNT_W(CW)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_we_i(req_we_i),
        .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o),
        .resp_rdata_o(resp_rdata_o),
        .resp_hit_o(resp_hit_o),
        .cache_addr_o(cache_addr_o),
        .cache_data_o(cache_data_o),
        .cache_wen_o(cache_wen_o),
        .cache_ren_o(cache_ren_o),
        .cache_hit_i(cache_hit_i),
        .cache_data_i(cache_data_i),
        .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i)
`ifdef FA_CTRL_STATS_EN
        ,
        .hit_cnt_o(hit_cnt_o),
        .miss_cnt_o(miss_cnt_o)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Device state (what the external cache / memory actually hold)
    logic [31:0] dev_mem   [logic [31:0]];
    logic [31:0] dev_cache [logic [31:0]];
    // Reference model state
    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] ref_cache [logic [31:0]];
    int ref_hits = 0;
    int ref_miss = 0;

    // Responder bookkeeping
    int          mem_delay    = 0;
    bit          spur_en      = 1'b0;
    int          mem_cnt      = 0;
    int          mtx_cnt      = 0;
    logic        mtx_we       = 1'b0;
    logic [31:0] mtx_addr     = '0;
    logic [31:0] mtx_wdata    = '0;
    logic        cap_we       = 1'b0;
    logic [31:0] cap_addr     = '0;
    logic [31:0] cap_wd       = '0;
    int          unstable_cnt = 0;
    int          overlap_cnt  = 0;
    int          wen_cnt      = 0;
    logic [31:0] wen_addr     = '0;
    logic [31:0] wen_data     = '0;
    int          resp_cnt     = 0;
    bit          prev_ren     = 1'b0;
    logic [31:0] prev_addr    = '0;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Cache and memory behaviour, updated away from the active edge.
    always @(negedge clk) begin
        if (cache_ren_o === 1'b1 && cache_wen_o === 1'b1) overlap_cnt++;
        if (resp_valid_o === 1'b1) resp_cnt++;
        // cache result is only meaningful the cycle after a ren
        if (prev_ren) begin
            cache_hit_i  = dev_cache.exists(prev_addr) ? 1'b1 : 1'b0;
            cache_data_i = cache_hit_i ? dev_cache[prev_addr] : $urandom;
        end else begin
            cache_hit_i  = ($urandom_range(0, 1) == 1);
            cache_data_i = $urandom;
        end
        prev_ren  = (cache_ren_o === 1'b1);
        prev_addr = cache_addr_o;
        if (cache_wen_o === 1'b1) begin
            dev_cache[cache_addr_o] = cache_data_o;
            wen_cnt++;
            wen_addr = cache_addr_o;
            wen_data = cache_data_o;
        end
        if (mem_req_o === 1'b1) begin
            if (mem_cnt == 0) begin
                cap_addr = mem_addr_o;
                cap_we   = mem_we_o;
                cap_wd   = mem_wdata_o;
            end else if (mem_addr_o !== cap_addr || mem_we_o !== cap_we ||
                         (cap_we && mem_wdata_o !== cap_wd)) begin
                unstable_cnt++;
            end
            if (mem_cnt >= mem_delay) begin
                mem_ack_i = 1'b1;
                mtx_cnt++;
                mtx_we    = mem_we_o;
                mtx_addr  = mem_addr_o;
                mtx_wdata = mem_wdata_o;
                if (mem_we_o === 1'b1) begin
                    dev_mem[mem_addr_o] = mem_wdata_o;
                    mem_rdata_i = $urandom;
                end else begin
                    mem_rdata_i = dev_mem.exists(mem_addr_o) ?
                                  dev_mem[mem_addr_o] : mem_init(mem_addr_o);
                end
                mem_cnt = 0;
            end else begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = $urandom;
                mem_cnt++;
            end
        end else begin
            mem_cnt     = 0;
            mem_ack_i   = spur_en ? ($urandom_range(0, 1) == 1) : 1'b0;
            mem_rdata_i = $urandom;
        end
    end

    // Issues one request; returns latency from the acceptance edge
    // (-1 on timeout), the response fields, and whether the response was a
    // single-cycle pulse with ready low during it and high right after.
    task automatic do_txn(input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input int delay,
                          output int lat, output logic [31:0] rd,
                          output logic hit, output bit pulse_ok);
        int k;
        @(negedge clk);
        mem_delay   = delay;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wd;
        k = 0;
        while (req_ready_o !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_we_i    = ($urandom_range(0, 1) == 1);
        req_addr_i  = $urandom;
        req_wdata_i = $urandom;
        lat = -1;
        rd = 'x;
        hit = 1'bx;
        pulse_ok = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (resp_valid_o === 1'b1) begin
                lat = c;
                rd = resp_rdata_o;
                hit = resp_hit_o;
                pulse_ok = (req_ready_o === 1'b0);
                @(negedge clk);
                pulse_ok = pulse_ok && (resp_valid_o === 1'b0) &&
                           (req_ready_o === 1'b1);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", req_ready_o); end
        total++; if (resp_valid_o !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b want=0", resp_valid_o); end
        total++; if (resp_rdata_o !== '0) begin bad++; $display("FAIL rst_resp_rdata got=%h want=0", resp_rdata_o); end
        total++; if (resp_hit_o !== 1'b0) begin bad++; $display("FAIL rst_resp_hit got=%b want=0", resp_hit_o); end
        total++; if ({cache_wen_o, cache_ren_o} !== 2'b00) begin bad++; $display("FAIL rst_cache_en got=%b%b want=00", cache_wen_o, cache_ren_o); end
        total++; if (cache_addr_o !== '0 || cache_data_o !== '0) begin bad++; $display("FAIL rst_cache_bus got=%h/%h want=0/0", cache_addr_o, cache_data_o); end
        total++; if ({mem_req_o, mem_we_o} !== 2'b00) begin bad++; $display("FAIL rst_mem_ctl got=%b%b want=00", mem_req_o, mem_we_o); end
        total++; if (mem_addr_o !== '0 || mem_wdata_o !== '0) begin bad++; $display("FAIL rst_mem_bus got=%h/%h want=0/0", mem_addr_o, mem_wdata_o); end
        ref_hits = 0;
        ref_miss = 0;
    endtask

    task automatic test_write();
        int lat, m0, w0;
        logic [31:0] rd;
        logic h;
        bit p;
        m0 = mtx_cnt;
        w0 = wen_cnt;
        do_txn(1'b1, 32'h0040_0000, 32'h0040_1234, 2, lat, rd, h, p);
        ref_cache[32'h0040_0000] = 32'h0040_1234;
        ref_mem[32'h0040_0000]   = 32'h0040_1234;
        total++; if (lat != 5) begin bad++; $display("FAIL wr_latency got=%0d want=5", lat); end
        total++; if (wen_cnt - w0 != 1 || wen_addr !== 32'h0040_0000 || wen_data !== 32'h0040_1234) begin bad++; $display("FAIL wr_cache got=%0d:%h:%h want=1:00400000:00401234", wen_cnt - w0, wen_addr, wen_data); end
        total++; if (mtx_cnt - m0 != 1 || mtx_we !== 1'b1 || mtx_addr !== 32'h0040_0000 || mtx_wdata !== 32'h0040_1234) begin bad++; $display("FAIL wr_mem got=%0d:%b:%h:%h want=1:1:00400000:00401234", mtx_cnt - m0, mtx_we, mtx_addr, mtx_wdata); end
        total++; if (rd !== 32'h0040_1234 || h !== 1'b0) begin bad++; $display("FAIL wr_resp got=%h/%b want=00401234/0", rd, h); end
        total++; if (!p) begin bad++; $display("FAIL wr_pulse got=0 want=1"); end
    endtask

    task automatic test_read_hit();
        int lat, m0;
        logic [31:0] rd;
        logic h;
        bit p;
        m0 = mtx_cnt;
        do_txn(1'b0, 32'h0040_0000, 32'h0, 0, lat, rd, h, p);
        ref_hits++;
        total++; if (lat != 3) begin bad++; $display("FAIL hit_latency got=%0d want=3", lat); end
        total++; if (rd !== 32'h0040_1234 || h !== 1'b1) begin bad++; $display("FAIL hit_resp got=%h/%b want=00401234/1", rd, h); end
        total++; if (mtx_cnt != m0) begin bad++; $display("FAIL hit_no_mem got=%0d want=0", mtx_cnt - m0); end
    endtask

    task automatic test_read_miss();
        int lat, m0, w0;
        logic [31:0] rd;
        logic h;
        bit p;
        m0 = mtx_cnt;
        w0 = wen_cnt;
        do_txn(1'b0, 32'h0000_0100, 32'h0, 0, lat, rd, h, p);
        ref_cache[32'h100] = 32'hDEAD_BEEF;
        ref_miss++;
        total++; if (lat != 5) begin bad++; $display("FAIL miss_latency got=%0d want=5", lat); end
        total++; if (rd !== 32'hDEAD_BEEF || h !== 1'b0) begin bad++; $display("FAIL miss_resp got=%h/%b want=deadbeef/0", rd, h); end
        total++; if (wen_cnt - w0 != 1 || wen_addr !== 32'h100 || wen_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL miss_fill got=%0d:%h:%h want=1:00000100:deadbeef", wen_cnt - w0, wen_addr, wen_data); end
        total++; if (mtx_cnt - m0 != 1 || mtx_we !== 1'b0 || mtx_addr !== 32'h100) begin bad++; $display("FAIL miss_mem got=%0d:%b:%h want=1:0:00000100", mtx_cnt - m0, mtx_we, mtx_addr); end
    endtask

    task automatic test_reset_mid();
        int k, r0, lat;
        logic [31:0] rd;
        logic h;
        bit p;
        spur_en = 1'b0;
        @(negedge clk);
        mem_delay   = 30;
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 32'h200;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        k = 0;
        while (mem_req_o !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL mid_reach_memrd got=%b want=1", mem_req_o); end
        r0  = resp_cnt;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ref_hits = 0;
        ref_miss = 0;
        total++; if (mem_req_o !== 1'b0 || req_ready_o !== 1'b1) begin bad++; $display("FAIL mid_abort got=req%b/rdy%b want=req0/rdy1", mem_req_o, req_ready_o); end
        total++; if (cache_addr_o !== '0 || mem_addr_o !== '0) begin bad++; $display("FAIL mid_regs_cleared got=%h/%h want=0/0", cache_addr_o, mem_addr_o); end
        repeat (5) @(negedge clk);
        total++; if (resp_cnt != r0) begin bad++; $display("FAIL mid_no_resp got=%0d want=0", resp_cnt - r0); end
        do_txn(1'b0, 32'h200, 32'h0, 1, lat, rd, h, p);
        ref_cache[32'h200] = mem_init(32'h200);
        ref_miss++;
        total++; if (h !== 1'b0 || lat != 6 || rd !== mem_init(32'h200)) begin bad++; $display("FAIL mid_remiss got=%b/%0d/%h want=0/6/%h", h, lat, rd, mem_init(32'h200)); end
    endtask

`ifdef FA_CTRL_STATS_EN
    task automatic test_stats();
        int lat;
        logic [31:0] rd;
        logic h;
        bit p;
        int eh, em;
        for (int i = 0; i < 5; i++) begin
            do_txn(1'b0, 32'h0040_0000, 32'h0, 0, lat, rd, h, p);
            ref_hits++;
        end
        eh = (ref_hits > 3) ? 3 : ref_hits;
        em = (ref_miss > 3) ? 3 : ref_miss;
        total++; if (int'(hit_cnt_o) != eh) begin bad++; $display("FAIL stats_hit got=%0d want=%0d", hit_cnt_o, eh); end
        total++; if (int'(miss_cnt_o) != em) begin bad++; $display("FAIL stats_miss got=%0d want=%0d", miss_cnt_o, em); end
    endtask
`endif

    task automatic test_random();
        bit we, exp_hit;
        logic [31:0] a, wd, exp_rd, rd;
        int d, exp_lat, lat, m0, w0;
        logic h;
        bit p;
        spur_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            we = ($urandom_range(0, 2) == 0);
            a  = 32'h1000 + (32'($urandom_range(0, 7)) << 2);
            wd = $urandom;
            d  = $urandom_range(0, 3);
            exp_hit = !we && ref_cache.exists(a);
            if (we) exp_rd = wd;
            else if (exp_hit) exp_rd = ref_cache[a];
            else exp_rd = ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
            exp_lat = we ? 2 + d + 1 : (exp_hit ? 3 : 4 + d + 1);
            m0 = mtx_cnt;
            w0 = wen_cnt;
            do_txn(we, a, wd, d, lat, rd, h, p);
            total++; if (lat != exp_lat) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, exp_lat); end
            total++; if (rd !== exp_rd || h !== exp_hit) begin bad++; $display("FAIL rnd%0d_resp got=%h/%b want=%h/%b", i, rd, h, exp_rd, exp_hit); end
            total++; if (!p) begin bad++; $display("FAIL rnd%0d_pulse got=0 want=1", i); end
            total++; if (mtx_cnt - m0 != (exp_hit ? 0 : 1)) begin bad++; $display("FAIL rnd%0d_memcount got=%0d want=%0d", i, mtx_cnt - m0, exp_hit ? 0 : 1); end
            total++; if (wen_cnt - w0 != (exp_hit ? 0 : 1)) begin bad++; $display("FAIL rnd%0d_wencount got=%0d want=%0d", i, wen_cnt - w0, exp_hit ? 0 : 1); end
            if (!exp_hit) begin
                total++; if (wen_addr !== a || wen_data !== exp_rd) begin bad++; $display("FAIL rnd%0d_cachewr got=%h:%h want=%h:%h", i, wen_addr, wen_data, a, exp_rd); end
                total++; if (mtx_we !== we || mtx_addr !== a || (we && mtx_wdata !== wd)) begin bad++; $display("FAIL rnd%0d_memtx got=%b:%h:%h want=%b:%h:%h", i, mtx_we, mtx_addr, mtx_wdata, we, a, wd); end
                ref_cache[a] = exp_rd;
            end
            if (we) ref_mem[a] = wd;
            else if (exp_hit) ref_hits++;
            else ref_miss++;
        end
        spur_en = 1'b0;
    endtask

    task automatic test_invariants();
        total++; if (overlap_cnt != 0) begin bad++; $display("FAIL ren_wen_overlap got=%0d want=0", overlap_cnt); end
        total++; if (unstable_cnt != 0) begin bad++; $display("FAIL mem_req_stable got=%0d want=0", unstable_cnt); end
`ifdef FA_CTRL_STATS_EN
        total++; if (int'(hit_cnt_o) != ((ref_hits > 3) ? 3 : ref_hits)) begin bad++; $display("FAIL stats_hit_final got=%0d want=%0d", hit_cnt_o, (ref_hits > 3) ? 3 : ref_hits); end
        total++; if (int'(miss_cnt_o) != ((ref_miss > 3) ? 3 : ref_miss)) begin bad++; $display("FAIL stats_miss_final got=%0d want=%0d", miss_cnt_o, (ref_miss > 3) ? 3 : ref_miss); end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_addr_i   = '0;
        req_wdata_i  = '0;
        cache_hit_i  = 1'b0;
        cache_data_i = '0;
        mem_ack_i    = 1'b0;
        mem_rdata_i  = '0;
        rst          = 1'b0;
        dev_mem[32'h100] = 32'hDEAD_BEEF;
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        test_reset();
        test_write();
        test_read_hit();
        test_read_miss();
        test_reset_mid();
`ifdef FA_CTRL_STATS_EN
        test_stats();
`endif
        test_random();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
